core_load_controller: RTL and testbench
=======================================

Name: core_load_controller

Overview:
Sequences the pipelined core from power-up through program load, execution and completion. It receives a byte stream (valid/ready), assembles little-endian 32-bit words and writes them into instruction memory. It then holds core_start high while the core runs, and stops on core_end or on a cycle timeout. It reports a cycle count and status until the host acknowledges, then re-arms for the next load.

Parameters:
IMEM_ADDR_W, 10, instruction-memory word-address width; depth = 2**IMEM_ADDR_W words
TIMEOUT_CYCLES, 32'd1000000, maximum RUN cycles before forced stop; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  byte valid
rx_data  in  8  byte payload
rx_ready  out  1  controller can accept a byte
imem_we  out  1  instruction-memory write strobe (one-cycle pulse)
imem_addr  out  IMEM_ADDR_W  word address of the write
imem_wdata  out  32  word to write
core_start  out  1  core run enable (low holds the PC at 0)
core_end  in  1  core finished
done_ack  in  1  host acknowledge; returns controller to load state
done  out  1  run finished
timeout  out  1  run stopped by timeout (valid while done=1)
overflow  out  1  program exceeded memory depth (sticky until the next load)
cycle_count  out  32  RUN cycles counted
state  out  3  current state, for debug: HDR=0, BODY=1, FLUSH=2, RUN=3, DONE=4

Behaviour:
- Byte transfer occurs on a posedge where rx_valid && rx_ready. rx_data is ignored otherwise.
- Reset (rst=1 at posedge, any state including mid-word or mid-run):
  - state=HDR
  - all outputs 0 except rx_ready=1
  - byte index, word index and partial word cleared
- rx_ready = (state==HDR || state==BODY). It stays 1 during write cycles in BODY.
- HDR state:
  - Accept 4 bytes, byte0 = LSB, forming N (32-bit word count).
  - On the 4th byte: if N==0, go to RUN. Otherwise clear the word index and go to BODY.
  - Entering HDR clears overflow.
- BODY state:
  - Assemble bytes LSB-first.
  - On the 4th byte of word i: if i < 2**IMEM_ADDR_W, the next cycle has imem_we=1, imem_addr=i[IMEM_ADDR_W-1:0], imem_wdata=word. Otherwise no write occurs and overflow<=1.
  - imem_addr and imem_wdata are registered and hold their value after the pulse.
  - If i == N-1, go to FLUSH; otherwise i<=i+1.
- FLUSH state: exactly 1 cycle, in which the final imem_we pulse occurs. Next state is RUN.
- RUN state:
  - core_start=1, a decode of the registered state (no extra latency).
  - cycle_count increments by 1 every RUN cycle, including the terminating cycle, and saturates at 32'hFFFFFFFF.
  - If core_end=1, go to DONE with timeout=0.
  - Else if TIMEOUT_CYCLES!=0 and the count after increment equals TIMEOUT_CYCLES, go to DONE with timeout=1.
  - If core_end and the timeout condition occur in the same cycle, core_end wins (timeout=0).
- DONE state:
  - done=1, core_start=0.
  - cycle_count, timeout and overflow hold.
  - rx_ready=0 and core_end is ignored.
  - On done_ack=1, go to HDR and clear done, timeout and cycle_count.
  - done_ack in any other state is ignored.
- Latency: core_start rises at the 2nd posedge after the last body-byte handshake (BODY -> FLUSH -> RUN). With N=0 it rises at the 1st posedge after the last header byte. core_start falls at the same edge at which done rises.
- Invalid state encodings recover to HDR on the next clock.

Test Plan:
- Reset: assert rst 2 cycles mid-BODY, then release -> state=0, rx_ready=1, imem_we=0, core_start=0, done=0, cycle_count=0; the next 4 bytes are taken as a new header.
- Load: bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> expect:
  - imem_we pulse at addr 0, data 0x00000013
  - imem_we pulse at addr 1, data 0x00100093
  - exactly 2 pulses
  - core_start=1 two cycles after the last byte
- Completion: after the load, raise core_end during the 10th RUN cycle -> done=1, core_start=0, cycle_count=10, timeout=0. done_ack -> state=HDR, cycle_count=0.
- Timeout: TIMEOUT_CYCLES=16, core_end held 0 -> done=1, timeout=1, cycle_count=16. Repeat with core_end=1 in the 16th cycle -> timeout=0.
- Overflow: IMEM_ADDR_W=2, N=5 -> 4 writes to addrs 0..3, no 5th write, overflow=1, RUN still entered. Overflow clears after done_ack.
- Empty and back-pressure:
  - N=0 header -> RUN on the next edge, no imem_we.
  - rx_valid held high during RUN/DONE -> no bytes consumed (rx_ready=0).
  - rx_valid toggled randomly in BODY -> word assembly is unaffected.

Source files
------------

// File: rtl/core_load_controller.sv
// core_load_controller: loads a byte-streamed program into instruction memory, then runs and times the core
module core_load_controller #(
  parameter int          IMEM_ADDR_W    = 10,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_start,
  input  logic                   core_end,
  input  logic                   done_ack,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow,
  output logic [31:0]            cycle_count,
  output logic [2:0]             state
);
  typedef enum logic [2:0] {HDR = 3'd0, BODY = 3'd1, FLUSH = 3'd2, RUN = 3'd3, DONE = 3'd4} state_t;
  state_t                 r_state;
  logic [1:0]             r_bidx;
  logic [23:0]            r_part;
  logic [31:0]            r_n;
  logic [31:0]            r_wi;
  logic                   r_we;
  logic [IMEM_ADDR_W-1:0] r_addr;
  logic [31:0]            r_wdata;
  logic                   r_to;
  logic                   r_ovf;
  logic [31:0]            r_cnt;
  logic                   w_take;
  logic                   w_last_byte;
  logic [31:0]            w_word;
  logic [31:0]            w_cnt_inc;
  logic                   w_fits;
  assign rx_ready    = (r_state == HDR) || (r_state == BODY);
  assign core_start  = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign state       = r_state;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign timeout     = r_to;
  assign overflow    = r_ovf;
  assign cycle_count = r_cnt;
  assign w_take      = rx_valid && rx_ready;
  assign w_last_byte = w_take && (r_bidx == 2'd3);
  assign w_word      = {rx_data, r_part};
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 32'd1;
  assign w_fits      = (r_wi >> IMEM_ADDR_W) == 32'd0;
  // Load/run/done sequencer; byte assembly shifts LSB-first so the 4th byte lands on top
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HDR;
      r_bidx  <= 2'd0;
      r_part  <= 24'd0;
      r_n     <= 32'd0;
      r_wi    <= 32'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_to    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (w_take) begin
        r_part <= {rx_data, r_part[23:8]};
        r_bidx <= r_bidx + 2'd1;
      end
      case (r_state)
        HDR: if (w_last_byte) begin
          r_n     <= w_word;
          r_wi    <= 32'd0;
          r_state <= (w_word == 32'd0) ? RUN : BODY;
        end
        BODY: if (w_last_byte) begin
          if (w_fits) begin
            r_we    <= 1'b1;
            r_addr  <= r_wi[IMEM_ADDR_W-1:0];
            r_wdata <= w_word;
          end else begin
            r_ovf <= 1'b1;
          end
          if (r_wi == r_n - 32'd1) r_state <= FLUSH;
          else r_wi <= r_wi + 32'd1;
        end
        FLUSH: r_state <= RUN;
        RUN: begin
          r_cnt <= w_cnt_inc;
          if (core_end) begin
            r_state <= DONE;
            r_to    <= 1'b0;
          end else if (TIMEOUT_CYCLES != 32'd0 && w_cnt_inc == TIMEOUT_CYCLES) begin
            r_state <= DONE;
            r_to    <= 1'b1;
          end
        end
        DONE: if (done_ack) begin
          r_state <= HDR;
          r_bidx  <= 2'd0;
          r_to    <= 1'b0;
          r_cnt   <= 32'd0;
          r_ovf   <= 1'b0;
        end
        default: begin
          r_state <= HDR;
          r_bidx  <= 2'd0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_load_controller.sv
// tb_core_load_controller: directed scenario checks for the load/run controller
module tb_core_load_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_start;
  logic        core_end = 1'b0;
  logic        done_ack = 1'b0;
  logic        done;
  logic        timeout;
  logic        overflow;
  logic [31:0] cycle_count;
  logic [2:0]  state;
  int total = 0;
  int bad = 0;
  int wr_n = 0;
  logic [1:0]  wa [0:15];
  logic [31:0] wd [0:15];
  core_load_controller #(.IMEM_ADDR_W(2), .TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_start(core_start),
    .core_end(core_end), .done_ack(done_ack), .done(done), .timeout(timeout), .overflow(overflow),
    .cycle_count(cycle_count), .state(state)
  );
  always #5 clk = ~clk;
  // record every write strobe seen mid-cycle
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 16) begin
        wa[wr_n] = imem_addr;
        wd[wr_n] = imem_wdata;
      end
      wr_n++;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic end_run();
    core_end = 1'b1;
    step();
    core_end = 1'b0;
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    send_word(32'd3);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_imem_we got=%b exp=0", imem_we); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycle_count got=%0d exp=0", cycle_count); end
    total++; if (overflow !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow, timeout); end
    wr_n = 0;
    send_word(32'd0);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL empty_state got=%0d exp=3", state); end
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL empty_core_start got=%b exp=1", core_start); end
    total++; if (wr_n !== 0) begin bad++; $display("FAIL empty_writes got=%0d exp=0", wr_n); end
    end_run();
  endtask
  task automatic test_load();
    logic [7:0] bytes [0:11];
    bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    wr_n = 0;
    for (int i = 0; i < 12; i++) send_byte(bytes[i]);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL load_flush_state got=%0d exp=2", state); end
    total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL load_flush_we got=%b exp=1", imem_we); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL load_early_start got=%b exp=0", core_start); end
    step();
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL load_core_start got=%b exp=1", core_start); end
    total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL load_we_pulse got=%b exp=0", imem_we); end
    total++; if (imem_addr !== 2'd1 || imem_wdata !== 32'h00100093) begin bad++; $display("FAIL load_hold got=%0d/%h exp=1/00100093", imem_addr, imem_wdata); end
    total++; if (wr_n !== 2) begin bad++; $display("FAIL load_count got=%0d exp=2", wr_n); end
    total++; if (wa[0] !== 2'd0 || wd[0] !== 32'h00000013) begin bad++; $display("FAIL load_w0 got=%0d/%h exp=0/00000013", wa[0], wd[0]); end
    total++; if (wa[1] !== 2'd1 || wd[1] !== 32'h00100093) begin bad++; $display("FAIL load_w1 got=%0d/%h exp=1/00100093", wa[1], wd[1]); end
  endtask
  task automatic test_complete();
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (9) step();
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL run_rx_ready got=%b exp=0", rx_ready); end
    total++; if (cycle_count !== 32'd9) begin bad++; $display("FAIL run_count9 got=%0d exp=9", cycle_count); end
    core_end = 1'b1;
    step();
    core_end = 1'b0;
    total++; if (done !== 1'b1 || core_start !== 1'b0) begin bad++; $display("FAIL cmp_done got=%b%b exp=10", done, core_start); end
    total++; if (cycle_count !== 32'd10) begin bad++; $display("FAIL cmp_count got=%0d exp=10", cycle_count); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL cmp_timeout got=%b exp=0", timeout); end
    core_end = 1'b1;
    step();
    step();
    core_end = 1'b0;
    total++; if (state !== 3'd4 || rx_ready !== 1'b0 || cycle_count !== 32'd10) begin bad++; $display("FAIL done_hold got=%0d/%b/%0d exp=4/0/10", state, rx_ready, cycle_count); end
    rx_valid = 1'b0;
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    total++; if (state !== 3'd0 || cycle_count !== 32'd0 || done !== 1'b0) begin bad++; $display("FAIL ack got=%0d/%0d/%b exp=0/0/0", state, cycle_count, done); end
    send_word(32'd0);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL no_consume got=%0d exp=3", state); end
    end_run();
  endtask
  task automatic test_timeout();
    send_word(32'd0);
    repeat (15) step();
    total++; if (state !== 3'd3 || cycle_count !== 32'd15) begin bad++; $display("FAIL to_pre got=%0d/%0d exp=3/15", state, cycle_count); end
    step();
    total++; if (done !== 1'b1 || timeout !== 1'b1 || cycle_count !== 32'd16) begin bad++; $display("FAIL to_hit got=%b%b/%0d exp=11/16", done, timeout, cycle_count); end
    step();
    total++; if (timeout !== 1'b1 || cycle_count !== 32'd16) begin bad++; $display("FAIL to_hold got=%b/%0d exp=1/16", timeout, cycle_count); end
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", timeout); end
    send_word(32'd0);
    repeat (15) step();
    core_end = 1'b1;
    step();
    core_end = 1'b0;
    total++; if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 32'd16) begin bad++; $display("FAIL to_tie got=%b%b/%0d exp=10/16", done, timeout, cycle_count); end
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
  endtask
  task automatic test_overflow();
    wr_n = 0;
    send_word(32'd5);
    for (int k = 0; k < 5; k++) send_word(32'hC0000000 | k);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    step();
    total++; if (state !== 3'd3) begin bad++; $display("FAIL ovf_run got=%0d exp=3", state); end
    total++; if (wr_n !== 4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", wr_n); end
    for (int k = 0; k < 4; k++) begin
      total++; if (wa[k] !== 2'(k) || wd[k] !== (32'hC0000000 | k)) begin bad++; $display("FAIL ovf_w%0d got=%0d/%h exp=%0d/%h", k, wa[k], wd[k], k, 32'hC0000000 | k); end
    end
    core_end = 1'b1;
    step();
    core_end = 1'b0;
    total++; if (overflow !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL ovf_done got=%b%b exp=11", overflow, done); end
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] words [0:2];
    words = '{32'd2, 32'hDEADBEEF, 32'h01234567};
    wr_n = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 3)) begin
          rx_data = 8'($urandom);
          step();
        end
        send_byte(words[w][8*i +: 8]);
      end
    end
    step();
    total++; if (wr_n !== 2) begin bad++; $display("FAIL gap_count got=%0d exp=2", wr_n); end
    total++; if (wa[0] !== 2'd0 || wd[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL gap_w0 got=%0d/%h exp=0/deadbeef", wa[0], wd[0]); end
    total++; if (wa[1] !== 2'd1 || wd[1] !== 32'h01234567) begin bad++; $display("FAIL gap_w1 got=%0d/%h exp=1/01234567", wa[1], wd[1]); end
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL gap_start got=%b exp=1", core_start); end
    end_run();
  endtask
  initial begin
    test_reset();
    test_load();
    test_complete();
    test_timeout();
    test_overflow();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
